// File: rtl/exec_muldiv_pkg.sv
// Shared decode constants, operation and state encodings for the RV32M execute unit.
package exec_muldiv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV);
  endfunction

endpackage

// File: rtl/exec_muldiv_if.sv
// Issue / writeback bundle between the exec stage and the multi-cycle mul/div unit.
interface exec_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            opcode_valid_i;
  logic [31:0]     opcode_opcode_i;
  logic [XLEN-1:0] opcode_ra_operand_i;
  logic [XLEN-1:0] opcode_rb_operand_i;
  logic            hold_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            writeback_valid_o;
  logic [XLEN-1:0] writeback_value_o;

  modport master (
    output opcode_valid_i, opcode_opcode_i, opcode_ra_operand_i, opcode_rb_operand_i,
    output hold_i, flush_i,
    input  ready_o, busy_o, writeback_valid_o, writeback_value_o
  );

  modport slave (
    input  opcode_valid_i, opcode_opcode_i, opcode_ra_operand_i, opcode_rb_operand_i,
    input  hold_i, flush_i,
    output ready_o, busy_o, writeback_valid_o, writeback_value_o
  );
endinterface

// File: rtl/exec_muldiv_div.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes, signs fixed on the last step.
module exec_muldiv_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            rem_sel,
  output logic            done_c,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic            neg_quo_q, neg_rem_q, rem_sel_q;

  logic            dvd_neg, dvs_neg;
  logic [XLEN-1:0] dvd_mag, dvs_mag;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] quo_n, rem_n;

  assign dvd_neg = is_signed & dividend[XLEN-1];
  assign dvs_neg = is_signed & divisor[XLEN-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // A clear borrow bit means the trial subtraction fits: keep it and shift in a 1.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_n = diff[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = shifted[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign done_c   = (cnt_q == CNT_W'(1));
  assign result_c = rem_sel_q ? (neg_rem_q ? -rem_n : rem_n)
                              : (neg_quo_q ? -quo_n : quo_n);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (start) begin
      quo_q     <= dvd_mag;
      rem_q     <= '0;
      dvs_q     <= dvs_mag;
      cnt_q     <= CNT_W'(XLEN);
      neg_quo_q <= dvd_neg ^ dvs_neg;
      neg_rem_q <= dvd_neg;
      rem_sel_q <= rem_sel;
    end else if (cnt_q != '0) begin
      quo_q <= quo_n;
      rem_q <= rem_n;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// RV32M execute unit: pipelined multiply, iterative divide, result held on writeback under hold_i.
module exec_muldiv
  import exec_muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  exec_muldiv_if.slave io
);

  localparam int unsigned PW        = 2 * XLEN + 2;
  localparam int unsigned MUL_CNT_W = (MUL_STAGES > 2) ? $clog2(MUL_STAGES - 1) : 1;
  localparam int unsigned MUL_LOAD  = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

  muldiv_state_e          state_q, state_d;
  logic [MUL_CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic                   wb_valid_q;
  logic [XLEN-1:0]        wb_value_q;
  logic                   wb_load;
  logic [XLEN-1:0]        wb_next;

  muldiv_op_e             op;
  logic                   is_m, is_div, div_signed, rem_sel, accept, ready_c;
  logic                   div_zero, div_ovf, div_done_c;
  logic [XLEN-1:0]        ra, rb, special_res, div_result_c, mul_res_c, mul_tail;
  logic signed [XLEN:0]   a_ext, b_ext;
  logic signed [PW-1:0]   prod;
  logic                   prod_unused, insn_unused;

  // Decode and accept
  assign ra         = io.opcode_ra_operand_i;
  assign rb         = io.opcode_rb_operand_i;
  assign is_m       = is_muldiv(io.opcode_opcode_i);
  assign op         = muldiv_op_e'(io.opcode_opcode_i[14:12]);
  assign is_div     = op inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  assign div_signed = op inside {F3_DIV, F3_REM};
  assign rem_sel    = op inside {F3_REM, F3_REMU};
  assign ready_c    = (state_q == S_IDLE) || ((state_q == S_DONE) && !io.hold_i);
  assign accept     = io.opcode_valid_i & ready_c & is_m & ~io.flush_i;
  assign insn_unused = ^{io.opcode_opcode_i[24:15], io.opcode_opcode_i[11:7]};

  // Divide corner cases bypass iteration entirely
  assign div_zero    = (rb == '0);
  assign div_ovf     = div_signed && (ra == {1'b1, {(XLEN-1){1'b0}}}) && (rb == '1);
  assign special_res = div_zero ? (rem_sel ? ra : '1) : (rem_sel ? '0 : ra);

  // Multiply from the accept-cycle operands; pipe registers give retiming slack
  always_comb begin
    a_ext = {(op inside {F3_MULH, F3_MULHSU}) & ra[XLEN-1], ra};
    b_ext = {(op == F3_MULH) & rb[XLEN-1], rb};
    prod  = PW'(a_ext) * PW'(b_ext);
  end
  assign mul_res_c   = (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign prod_unused = ^prod[PW-1:2*XLEN];

  if (MUL_STAGES > 1) begin : g_pipe
    logic [XLEN-1:0] pipe_q [MUL_STAGES-1];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(MUL_STAGES) - 1; i++) pipe_q[i] <= '0;
      end else begin
        if (accept && !is_div) pipe_q[0] <= mul_res_c;
        for (int i = 1; i < int'(MUL_STAGES) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_tail = pipe_q[MUL_STAGES-2];
  end else begin : g_nopipe
    assign mul_tail = mul_res_c;
  end

  exec_muldiv_div #(.XLEN(XLEN)) u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (accept & is_div),
    .dividend  (ra),
    .divisor   (rb),
    .is_signed (div_signed),
    .rem_sel   (rem_sel),
    .done_c    (div_done_c),
    .result_c  (div_result_c)
  );

  // Next state and writeback load
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    wb_load   = 1'b0;
    wb_next   = mul_tail;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && !io.hold_i) state_d = S_IDLE;
        if (accept) begin
          if (is_div) begin
            if (div_zero || div_ovf) begin
              state_d = S_DONE;
              wb_load = 1'b1;
              wb_next = special_res;
            end else begin
              state_d = S_DIV;
            end
          end else if (MUL_STAGES == 1) begin
            state_d = S_DONE;
            wb_load = 1'b1;
            wb_next = mul_tail;
          end else begin
            state_d   = S_MUL;
            mul_cnt_d = MUL_CNT_W'(MUL_LOAD);
          end
        end
      end
      S_MUL: begin
        if (mul_cnt_q == '0) begin
          state_d = S_DONE;
          wb_load = 1'b1;
          wb_next = mul_tail;
        end else begin
          mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
        end
      end
      S_DIV: begin
        if (div_done_c) begin
          state_d = S_DONE;
          wb_load = 1'b1;
          wb_next = div_result_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (io.flush_i) begin
      state_d = S_IDLE;
      wb_load = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      mul_cnt_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_value_q <= '0;
    end else begin
      state_q    <= state_d;
      mul_cnt_q  <= mul_cnt_d;
      wb_valid_q <= (state_d == S_DONE);
      if (wb_load) wb_value_q <= wb_next;
    end
  end

  assign io.ready_o           = ready_c;
  assign io.busy_o            = (state_q != S_IDLE);
  assign io.writeback_valid_o = wb_valid_q;
  assign io.writeback_value_o = wb_value_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv: latencies, results, hold, flush and reset behaviour.
module tb_exec_muldiv;
  import exec_muldiv_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_i;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  exec_muldiv_if #(.XLEN(XLEN)) bus ();

  exec_muldiv #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .io    (bus)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OPC_OP};
  endfunction

  task automatic offer(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.opcode_valid_i      = 1'b1;
    bus.opcode_opcode_i     = insn(F7_MULDIV, f3);
    bus.opcode_ra_operand_i = a;
    bus.opcode_rb_operand_i = b;
  endtask

  // Issue one op, measure cycles from accept to valid, then let DONE drain to IDLE
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int lat, input logic [XLEN-1:0] exp);
    int cyc;
    offer(f3, a, b);
    tick();
    bus.opcode_valid_i = 1'b0;
    cyc = 1;
    while (bus.writeback_valid_o !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_val"}, bus.writeback_value_o, exp);
    tick();
  endtask

  initial begin
    logic seen;
    rst_i                   = 1'b1;
    bus.opcode_valid_i      = 1'b0;
    bus.opcode_opcode_i     = '0;
    bus.opcode_ra_operand_i = '0;
    bus.opcode_rb_operand_i = '0;
    bus.hold_i              = 1'b0;
    bus.flush_i             = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.writeback_valid_o), 32'd0);
    chk("rst_value", bus.writeback_value_o, 32'd0);
    chk("rst_busy",  32'(bus.busy_o), 32'd0);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    rst_i = 1'b0;
    tick();

    // MUL 7*-3 with hold kept high so the result stays in DONE
    bus.hold_i = 1'b1;
    offer(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    #1 chk("mul_rdy_c0", 32'(bus.ready_o), 32'd1);
    tick();
    bus.opcode_valid_i = 1'b0;
    #1;
    chk("mul_rdy_c1", 32'(bus.ready_o), 32'd0);
    chk("mul_vld_c1", 32'(bus.writeback_valid_o), 32'd0);
    chk("mul_busy_c1", 32'(bus.busy_o), 32'd1);
    tick();
    chk("mul_vld_c2", 32'(bus.writeback_valid_o), 32'd1);
    chk("mul_val_c2", bus.writeback_value_o, 32'hFFFF_FFEB);
    chk("mul_rdy_c2", 32'(bus.ready_o), 32'd0);
    bus.hold_i = 1'b0;
    #1 chk("mul_rdy_rel", 32'(bus.ready_o), 32'd1);
    tick();
    chk("mul_idle_vld", 32'(bus.writeback_valid_o), 32'd0);
    chk("mul_idle_keep", bus.writeback_value_o, 32'hFFFF_FFEB);

    // Multiply high variants
    run_op("mulh",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         2, 32'hFFFF_FFFF);
    run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'd2,         2, 32'h0000_0001);

    // Iterative divide
    run_op("div",  F3_DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    run_op("rem",  F3_REM,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    run_op("divu", F3_DIVU, 32'd100,       32'd7, 33, 32'd14);
    run_op("remu", F3_REMU, 32'd100,       32'd7, 33, 32'd2);

    // Divide special cases
    run_op("div0",    F3_DIV,  32'd5,         32'd0,         1, 32'hFFFF_FFFF);
    run_op("remu0",   F3_REMU, 32'd5,         32'd0,         1, 32'd5);
    run_op("div_ovf", F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf", F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

    // Non-M opcode is ignored
    bus.opcode_valid_i  = 1'b1;
    bus.opcode_opcode_i = insn(7'b0000000, 3'd0);
    tick();
    bus.opcode_valid_i = 1'b0;
    chk("nonm_busy", 32'(bus.busy_o), 32'd0);
    chk("nonm_vld",  32'(bus.writeback_valid_o), 32'd0);

    // Hold for 4 cycles, then back-to-back accept on release
    bus.hold_i = 1'b1;
    offer(F3_MUL, 32'd6, 32'd7);
    tick();
    offer(F3_DIVU, 32'd9, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("hold_vld", 32'(bus.writeback_valid_o), 32'd1);
      chk("hold_val", bus.writeback_value_o, 32'd42);
      tick();
    end
    bus.hold_i = 1'b0;
    offer(F3_MUL, 32'd3, 32'd5);
    #1 chk("b2b_rdy", 32'(bus.ready_o), 32'd1);
    tick();
    bus.opcode_valid_i = 1'b0;
    chk("b2b_vld_c1", 32'(bus.writeback_valid_o), 32'd0);
    chk("b2b_busy_c1", 32'(bus.busy_o), 32'd1);
    tick();
    chk("b2b_vld_c2", 32'(bus.writeback_valid_o), 32'd1);
    chk("b2b_val_c2", bus.writeback_value_o, 32'd15);
    tick();

    // Flush at divide iteration 10 with a competing offer
    offer(F3_DIVU, 32'd1000, 32'd3);
    tick();
    bus.opcode_valid_i = 1'b0;
    repeat (9) tick();
    bus.flush_i = 1'b1;
    offer(F3_MUL, 32'd2, 32'd2);
    tick();
    bus.flush_i        = 1'b0;
    bus.opcode_valid_i = 1'b0;
    #1;
    chk("flush_busy", 32'(bus.busy_o), 32'd0);
    chk("flush_vld",  32'(bus.writeback_valid_o), 32'd0);
    chk("flush_rdy",  32'(bus.ready_o), 32'd1);
    chk("flush_keep", bus.writeback_value_o, 32'd15);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= bus.writeback_valid_o;
    end
    chk("flush_never_vld", 32'(seen), 32'd0);

    // Reset mid-multiply
    offer(F3_MUL, 32'd9, 32'd9);
    tick();
    bus.opcode_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("rstmid_busy", 32'(bus.busy_o), 32'd0);
    chk("rstmid_rdy",  32'(bus.ready_o), 32'd1);
    chk("rstmid_val",  bus.writeback_value_o, 32'd0);
    tick();
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= bus.writeback_valid_o;
    end
    chk("rstmid_never_vld", 32'(seen), 32'd0);
    chk("rstmid_rdy_after", 32'(bus.ready_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
